// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the MIPS instruction memory.
//
// Accepts a framed, big-endian byte stream (LEN_HI, LEN_LO, then 4*N data
// bytes, MSB first per word) and writes each assembled 32-bit word through a
// single-cycle write port at BASE_ADDR + 4*k. The core is held in reset until
// the whole image is in.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing byte must equal the XOR of all data bytes;
//   a mismatch sends the loader to ERR.
//
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   in_valid/in_data  - byte stream source
//   in_ready          - a byte is accepted when in_valid && in_ready
//   load_req          - restart a load from DONE or ERR
//   wr_en/addr/data   - instruction memory write port (one-cycle strobe)
//   core_reset        - core reset, low only in DONE
//   done, error       - status flags
//   words_loaded      - words written in the current load
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  load_req,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [31:0]           wr_data,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t      state, next;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        xfer;
    logic [15:0] len_now;
    logic        word_done;
    logic        last_word;
    logic        reload;

    assign xfer      = in_valid && in_ready;
    assign len_now   = {len_hi, in_data};
    assign word_done = xfer && (state == S_DATA) && (byte_cnt == 2'd3);
    assign last_word = (32'(words_loaded) + 32'd1) == {16'd0, len};
    assign reload    = ((state == S_DONE) || (state == S_ERR)) && load_req;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_LEN_HI;
        else       state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            S_LEN_HI: if (xfer) next = S_LEN_LO;
            S_LEN_LO: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (len_now == 16'd0)                next = S_CHK;
`else
                if (len_now == 16'd0)                next = S_DONE;
`endif
                else if ({16'd0, len_now} > CAPACITY) next = S_ERR;
                else                                  next = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_DATA:   if (word_done && last_word) next = S_CHK;
            S_CHK:    if (xfer) next = (in_data == csum) ? S_DONE : S_ERR;
`else
            S_DATA:   if (word_done && last_word) next = S_DONE;
`endif
            S_DONE,
            S_ERR:    if (load_req) next = S_LEN_HI;
            default:  next = S_LEN_HI;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        in_ready   = !reset && (state != S_DONE) && (state != S_ERR);
        done       = (state == S_DONE);
        error      = (state == S_ERR);
        core_reset = (state != S_DONE);
    end

    // Datapath: length capture, word assembly, write port
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en        <= 1'b0;
            wr_addr      <= BASE_ADDR;
            wr_data      <= 32'd0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            shift        <= 24'd0;
            len_hi       <= 8'd0;
            len          <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (xfer && state == S_LEN_HI) len_hi <= in_data;
            if (xfer && state == S_LEN_LO) len    <= len_now;
            if (xfer && state == S_DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {shift[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ in_data;
`endif
                if (byte_cnt == 2'd3) begin
                    wr_en        <= 1'b1;
                    wr_data      <= {shift, in_data};
                    // 32-bit add, wraps naturally past 2**32
                    wr_addr      <= BASE_ADDR + (32'(words_loaded) << 2);
                    words_loaded <= words_loaded + 1'b1;
                end
            end
            if (reload) begin
                words_loaded <= '0;
                byte_cnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum         <= 8'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A frame-level model (the queue of
// bytes accepted in the current frame) predicts every output each cycle;
// directed frames add literal expectations on the resulting writes.
module tb_imem_loader;
    localparam int          AW   = 2;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;   // exercises address wrap
    localparam int          CAP  = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, in_valid, load_req;
    logic [7:0]    in_data;
    logic          in_ready, wr_en, core_reset, done, error;
    logic [31:0]   wr_addr, wr_data;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_req(load_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_reset(core_reset),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_on = 1'b0;
    logic [7:0]  rx[$];          // bytes accepted in current frame (model)
    logic [7:0]  fr[$];          // frame to send
    logic [63:0] wlog[$];        // observed DUT writes {addr, data}
    bit          exp_wr = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_data = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = loading, 1 = done, 2 = error
    function automatic int status();
        int n, need;
        logic [7:0] x;
        if (rx.size() < 2) return 0;
        n = int'({rx[0], rx[1]});
        if (n > CAP) return 2;
        need = 2 + 4 * n + (CSUM ? 1 : 0);
        if (rx.size() < need) return 0;
        if (!CSUM) return 1;
        x = 8'd0;
        for (int i = 2; i < need - 1; i++) x ^= rx[i];
        return (x == rx[need-1]) ? 1 : 2;
    endfunction

    function automatic int words();
        int n, w;
        if (rx.size() < 2) return 0;
        n = int'({rx[0], rx[1]});
        if (n > CAP) return 0;
        w = (rx.size() - 2) / 4;
        return (w > n) ? n : w;
    endfunction

    // Model update on each rising edge
    initial begin : model
        int st, s, k;
        forever begin
            @(posedge clock);
            exp_wr = 1'b0;
            if (reset) rx.delete();
            else begin
                st = status();
                if (st == 0 && in_valid) begin
                    rx.push_back(in_data);
                    s = rx.size();
                    if (s >= 6 && (s - 2) % 4 == 0) begin
                        k = (s - 2) / 4 - 1;
                        exp_wr   = 1'b1;
                        exp_addr = BASE + 32'(4 * k);
                        exp_data = {rx[s-4], rx[s-3], rx[s-2], rx[s-1]};
                    end
                end else if (st != 0 && load_req) rx.delete();
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin : compare
        int st;
        forever begin
            @(negedge clock);
            if (chk_on) begin
                st = status();
                check("wr_en", 64'(wr_en), 64'(exp_wr));
                if (exp_wr) begin
                    check("wr_addr", 64'(wr_addr), 64'(exp_addr));
                    check("wr_data", 64'(wr_data), 64'(exp_data));
                end
                check("done", 64'(done), 64'(st == 1));
                check("error", 64'(error), 64'(st == 2));
                check("core_reset", 64'(core_reset), 64'(st != 1));
                check("in_ready", 64'(in_ready), 64'(!reset && st == 0));
                check("words_loaded", 64'(words_loaded), 64'(words()));
                if (wr_en) wlog.push_back({wr_addr, wr_data});
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            t++;
            if (t > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_byte: in_ready low for %0d cycles, required 1", t);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends fr; optional 3-cycle in_valid gap after byte gap_after.
    // csum < 0: append computed checksum (checksum builds only).
    task automatic send_frame(input int gap_after, input int csum);
        int n;
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i]);
            if (i >= 2) x ^= fr[i];
            if (i + 1 == gap_after) idle(3);
        end
        n = int'({fr[0], fr[1]});
        if (CSUM && fr.size() == 2 + 4 * n) send_byte(csum < 0 ? x : 8'(csum));
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clock);
        #1;
        load_req = 1'b0;
        check("reload core_reset", 64'(core_reset), 64'd1);
        check("reload in_ready", 64'(in_ready), 64'd1);
        wlog.delete();
    endtask

    task automatic check_two_word_image(input string tag);
        check({tag, " nwrites"}, 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            check({tag, " w0"}, wlog[0], {32'hFFFF_FFF8, 32'h2408_0005});
            check({tag, " w1"}, wlog[1], {32'hFFFF_FFFC, 32'h0109_5020});
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " core_reset"}, 64'(core_reset), 64'd0);
        check({tag, " words"}, 64'(words_loaded), 64'd2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; load_req = 1'b0;
        @(posedge clock); #1;
        chk_on = 1'b1;
        check("rst wr_en", 64'(wr_en), 64'd0);
        check("rst wr_addr", 64'(wr_addr), 64'hFFFF_FFF8);
        check("rst wr_data", 64'(wr_data), 64'd0);
        check("rst core_reset", 64'(core_reset), 64'd1);
        check("rst done", 64'(done), 64'd0);
        check("rst error", 64'(error), 64'd0);
        check("rst words", 64'(words_loaded), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Two-word image, continuous stream
        wlog.delete();
        fr = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send_frame(-1, -1);
        idle(2);
        check_two_word_image("t1");

        // Same image with a 3-cycle gap after byte 4
        pulse_load();
        send_frame(4, -1);
        idle(2);
        check_two_word_image("t2");

        // Oversized length: N = 5 > 4
        pulse_load();
        fr = {8'h00, 8'h05};
        send_frame(-1, -1);
        idle(2);
        check("t3 error", 64'(error), 64'd1);
        check("t3 core_reset", 64'(core_reset), 64'd1);
        check("t3 in_ready", 64'(in_ready), 64'd0);
        check("t3 nwrites", 64'(wlog.size()), 64'd0);

        // Full capacity, addresses wrap past 2**32
        pulse_load();
        fr = {8'h00, 8'h04};
        for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
        send_frame(-1, -1);
        idle(2);
        check("t4 nwrites", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            check("t4 w1", wlog[1], {32'hFFFF_FFFC, 32'h0506_0708});
            check("t4 w2", wlog[2], {32'h0000_0000, 32'h090A_0B0C});
            check("t4 w3", wlog[3], {32'h0000_0004, 32'h0D0E_0F10});
        end
        check("t4 words", 64'(words_loaded), 64'd4);

        // Reset in mid-word, then a clean 1-word frame
        pulse_load();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t5 rst core_reset", 64'(core_reset), 64'd1);
        check("t5 rst wr_en", 64'(wr_en), 64'd0);
        reset = 1'b0;
        fr = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(-1, -1);
        idle(2);
        check("t5 nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) check("t5 w0", wlog[0], {32'hFFFF_FFF8, 32'hAABB_CCDD});
        check("t5 done", 64'(done), 64'd1);

        // Empty image reload
        pulse_load();
        fr = {8'h00, 8'h00};
        send_frame(-1, -1);
        idle(2);
        check("t6 done", 64'(done), 64'd1);
        check("t6 words", 64'(words_loaded), 64'd0);
        check("t6 nwrites", 64'(wlog.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum good / bad
        pulse_load();
        fr = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(-1, 8'h44);
        idle(2);
        check("t7 good done", 64'(done), 64'd1);
        pulse_load();
        send_frame(-1, 8'h45);
        idle(2);
        check("t7 bad error", 64'(error), 64'd1);
        check("t7 bad core_reset", 64'(core_reset), 64'd1);
        check("t7 bad nwrites", 64'(wlog.size()), 64'd1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
